// File: rtl/divider_control_unit.sv
// -----------------------------------------------------------------------------
// divider_control_unit
//
// Purpose
//   Sequencer for a restoring divider datapath. A Moore-style FSM issues the
//   load / shift / subtract / restore / quotient-bit strobes. It drives the
//   enable of an external registered iteration incrementer and reads that
//   incrementer's count back to stop after N passes. Towards the ALU top the
//   handshake is start in, busy/done out.
//
// Parameters
//   N      operand width, which is also the number of iterations
//   CNT_W  width of the iteration count coming back from the incrementer
//
// Ports
//   clk           in   rising-edge clock
//   rst_b         in   asynchronous reset, active low
//   start         in   request a new division; only looked at in IDLE
//   cnt           in   registered iteration count (incrementer output)
//   a_msb         in   sign of the partial remainder A after the subtract
//   divisor_zero  in   divisor being loaded into M equals zero
//   cnt_clr       out  clear the iteration count register
//   load_a        out  clear the partial remainder A
//   load_q        out  load the dividend into Q
//   load_m        out  load the divisor into M
//   shift_left    out  shift {A,Q} left by one
//   sub           out  A <= A - M
//   add_restore   out  A <= A + M
//   q0_set        out  Q[0] <= 1
//   inc_en        out  incrementer enable
//   out_en        out  latch quotient/remainder into the result registers
//   busy          out  FSM is not in IDLE
//   done          out  one-cycle completion pulse
//   div_by_zero   out  one-cycle divide-by-zero error pulse
//
// Build option
//   DIV_BY_ZERO_CHECK_EN : when defined, a zero divisor seen in LOAD diverts
//   to a short ERR state that pulses done and div_by_zero without touching
//   the result registers. When undefined, the ERR state does not exist,
//   divisor_zero is ignored and div_by_zero is tied low; a zero divisor then
//   runs all N passes and gives an all-ones quotient with the remainder
//   equal to the dividend.
// -----------------------------------------------------------------------------
module divider_control_unit #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic             a_msb,
  input  logic             divisor_zero,
  output logic             cnt_clr,
  output logic             load_a,
  output logic             load_q,
  output logic             load_m,
  output logic             shift_left,
  output logic             sub,
  output logic             add_restore,
  output logic             q0_set,
  output logic             inc_en,
  output logic             out_en,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SHIFT   = 4'd2,
    S_SUB     = 4'd3,
    S_TEST    = 4'd4,
    S_RESTORE = 4'd5,
    S_COUNT   = 4'd6,
    S_DONE    = 4'd7
`ifdef DIV_BY_ZERO_CHECK_EN
    , S_ERR   = 4'd8
`endif
  } state_t;

  // The incrementer is registered, so COUNT sees the count from before its
  // own increment. The last pass therefore shows N-1, not N.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t state_q;
  state_t state_d;

`ifndef DIV_BY_ZERO_CHECK_EN
  // Without the error path the zero-divisor flag has no consumer.
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
`endif

  // State register. Reset takes effect at once, even in the middle of a
  // division. Because every output is decoded from this register, all
  // strobes drop together and no partial result is ever flagged.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only considered in IDLE, so start pulses
  // while busy are ignored (this includes a pulse during DONE).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef DIV_BY_ZERO_CHECK_EN
        if (divisor_zero) begin
          state_d = S_ERR;
        end else begin
          state_d = S_SHIFT;
        end
`else
        state_d = S_SHIFT;
`endif
      end
      S_SHIFT: begin
        state_d = S_SUB;
      end
      S_SUB: begin
        state_d = S_TEST;
      end
      S_TEST: begin
        // A negative trial remainder means the subtract overshot and has
        // to be undone before the pass is counted.
        if (a_msb) begin
          state_d = S_RESTORE;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_RESTORE: begin
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (cnt == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef DIV_BY_ZERO_CHECK_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. Each state owns its own strobes, so no two datapath
  // operations can ever coincide. The one exception to pure state decode is
  // q0_set in TEST: it is qualified by a_msb so that a successful subtract
  // records its quotient bit in the same cycle it is tested.
  always_comb begin
    cnt_clr     = 1'b0;
    load_a      = 1'b0;
    load_q      = 1'b0;
    load_m      = 1'b0;
    shift_left  = 1'b0;
    sub         = 1'b0;
    add_restore = 1'b0;
    q0_set      = 1'b0;
    inc_en      = 1'b0;
    out_en      = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        load_a  = 1'b1;
        load_q  = 1'b1;
        load_m  = 1'b1;
        cnt_clr = 1'b1;
      end
      S_SHIFT: begin
        shift_left = 1'b1;
      end
      S_SUB: begin
        sub = 1'b1;
      end
      S_TEST: begin
        q0_set = ~a_msb;
      end
      S_RESTORE: begin
        add_restore = 1'b1;
      end
      S_COUNT: begin
        inc_en = 1'b1;
      end
      S_DONE: begin
        out_en = 1'b1;
        done   = 1'b1;
      end
`ifdef DIV_BY_ZERO_CHECK_EN
      // The error exit reports completion but leaves the results alone.
      S_ERR: begin
        done        = 1'b1;
        div_by_zero = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_divider_control_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_control_unit
//
// Wraps divider_control_unit with a small behavioural restoring-divider
// datapath that reacts to the strobes. Every launched division pushes an
// expected outcome into a scoreboard queue. That outcome is computed from
// plain integer division: quotient, remainder, number of set quotient bits,
// number of restores, and the resulting latency. A separate monitor pops
// the queue on each done pulse and compares.
// -----------------------------------------------------------------------------
module tb_divider_control_unit;

  localparam int N     = 8;
  localparam int CNT_W = $clog2(N) + 1;

  localparam int C_NONE  = 0;
  localparam int C_LOAD  = 1;
  localparam int C_SHIFT = 2;
  localparam int C_SUB   = 3;
  localparam int C_Q0    = 4;
  localparam int C_REST  = 5;
  localparam int C_INC   = 6;
  localparam int C_DONE  = 7;
  localparam int C_ERR   = 8;

  typedef struct {
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    int           lat;
    int           q0s;
    int           rests;
    int           incs;
    bit           dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;
  logic start;
  logic [CNT_W-1:0] cnt;
  logic a_msb;
  logic divisor_zero;
  logic cnt_clr, load_a, load_q, load_m, shift_left, sub, add_restore;
  logic q0_set, inc_en, out_en, busy, done, div_by_zero;

  logic [N-1:0] dividend_in = '0;
  logic [N-1:0] divisor_in  = '0;
  logic [N:0]       a_reg   = '0;
  logic [N-1:0]     q_reg   = '0;
  logic [N-1:0]     m_reg   = '0;
  logic [N-1:0]     res_q   = '0;
  logic [N-1:0]     res_r   = '0;
  logic [CNT_W-1:0] cnt_reg = '0;

  logic [11:0] strobes;
  logic [12:0] outs;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int n_pushed = 0;
  int total_done = 0;
  int n_load = 0;
  int n_q0, n_rest, n_inc, n_out;
  int cyc, onehot_bad, order_bad, busy_bad;
  int idle_bad = 0;
  int last_code = C_NONE;
  bit active = 1'b0;
  bit res_pending = 1'b0;
  logic [N-1:0] snap_q, snap_r;

  always #5 clk = ~clk;

  divider_control_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .cnt          (cnt),
    .a_msb        (a_msb),
    .divisor_zero (divisor_zero),
    .cnt_clr      (cnt_clr),
    .load_a       (load_a),
    .load_q       (load_q),
    .load_m       (load_m),
    .shift_left   (shift_left),
    .sub          (sub),
    .add_restore  (add_restore),
    .q0_set       (q0_set),
    .inc_en       (inc_en),
    .out_en       (out_en),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero)
  );

  assign strobes = {cnt_clr, load_a, load_q, load_m,
                    shift_left, sub, add_restore, q0_set,
                    inc_en, out_en, done, div_by_zero};
  assign outs    = {strobes, busy};

  // Environment datapath: the registers the strobes act on, plus the
  // registered iteration incrementer.
  assign cnt          = cnt_reg;
  assign a_msb        = a_reg[N];
  assign divisor_zero = (divisor_in == '0);

  always @(posedge clk) begin
    if (cnt_clr) cnt_reg <= '0;
    else if (inc_en) cnt_reg <= cnt_reg + 1'b1;
    if (load_a) a_reg <= '0;
    else if (shift_left) a_reg <= {a_reg[N-1:0], q_reg[N-1]};
    else if (sub) a_reg <= a_reg - {1'b0, m_reg};
    else if (add_restore) a_reg <= a_reg + {1'b0, m_reg};
    if (load_q) q_reg <= dividend_in;
    else if (shift_left) q_reg <= {q_reg[N-2:0], 1'b0};
    else if (q0_set) q_reg[0] <= 1'b1;
    if (load_m) m_reg <= divisor_in;
    if (out_en) begin
      res_q <= q_reg;
      res_r <= a_reg[N-1:0];
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: the outcome follows from ordinary integer division.
  function automatic exp_t refModel(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    exp_t e;
    e.dbz = 1'b0;
    if (dvs == '0) begin
`ifdef DIV_BY_ZERO_CHECK_EN
      e.dbz   = 1'b1;
      e.quo   = '0;
      e.rem   = '0;
      e.q0s   = 0;
      e.rests = 0;
      e.incs  = 0;
      e.lat   = 2;
      return e;
`else
      e.quo = '1;
      e.rem = dvd;
`endif
    end else begin
      e.quo = dvd / dvs;
      e.rem = dvd % dvs;
    end
    e.q0s   = $countones(e.quo);
    e.rests = N - e.q0s;
    e.incs  = N;
    e.lat   = 1 + 4 * N + e.rests + 1;
    return e;
  endfunction

  function automatic int classify(input logic [11:0] s);
    case (s)
      12'b0000_0000_0000: return C_NONE;
      12'b1111_0000_0000: return C_LOAD;
      12'b0000_1000_0000: return C_SHIFT;
      12'b0000_0100_0000: return C_SUB;
      12'b0000_0010_0000: return C_REST;
      12'b0000_0001_0000: return C_Q0;
      12'b0000_0000_1000: return C_INC;
      12'b0000_0000_0110: return C_DONE;
      12'b0000_0000_0011: return C_ERR;
      default:            return -1;
    endcase
  endfunction

  function automatic bit predOk(input int code, input int last);
    case (code)
      C_SHIFT: return (last == C_LOAD) || (last == C_INC);
      C_SUB:   return last == C_SHIFT;
      C_Q0:    return last == C_SUB;
      C_REST:  return last == C_SUB;
      C_INC:   return (last == C_Q0) || (last == C_REST);
      C_DONE:  return last == C_INC;
      C_ERR:   return last == C_LOAD;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: tracks each division from its LOAD cycle and checks the
  // outcome against the scoreboard whenever done is presented.
  initial begin : monitor
    exp_t e;
    exp_t pend;
    int code;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        active      = 1'b0;
        res_pending = 1'b0;
        last_code   = C_NONE;
        continue;
      end
      if (res_pending) begin
        res_pending = 1'b0;
        if (pend.dbz) begin
          checkOutput("dbz_res_q_kept", res_q, snap_q);
          checkOutput("dbz_res_r_kept", res_r, snap_r);
        end else begin
          checkOutput("quotient", res_q, pend.quo);
          checkOutput("remainder", res_r, pend.rem);
        end
      end
      if (!busy && strobes != '0) idle_bad++;
      code = classify(strobes);
      if (code == C_LOAD) begin
        active = 1'b1;
        cyc = 0; n_q0 = 0; n_rest = 0; n_inc = 0; n_out = 0;
        onehot_bad = 0; order_bad = 0; busy_bad = 0;
        snap_q = res_q;
        snap_r = res_r;
        n_load++;
        last_code = C_LOAD;
      end else if (code < 0) begin
        onehot_bad++;
      end else if (code != C_NONE) begin
        if (!predOk(code, last_code)) order_bad++;
        last_code = code;
      end
      if (active) begin
        cyc++;
        if (!busy) busy_bad++;
      end else if (busy) begin
        idle_bad++;
      end
      n_q0   += int'(q0_set);
      n_rest += int'(add_restore);
      n_inc  += int'(inc_en);
      n_out  += int'(out_en);
      if (done) begin
        total_done++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("latency", cyc, e.lat);
          checkOutput("div_by_zero", div_by_zero, e.dbz);
          checkOutput("out_en_count", n_out, e.dbz ? 0 : 1);
          checkOutput("q0_set_count", n_q0, e.q0s);
          checkOutput("restore_count", n_rest, e.rests);
          checkOutput("inc_en_count", n_inc, e.incs);
          checkOutput("onehot_bad", onehot_bad, 0);
          checkOutput("order_bad", order_bad, 0);
          checkOutput("busy_bad", busy_bad, 0);
          pend = e;
          res_pending = 1'b1;
        end
        active = 1'b0;
      end
    end
  end

  task automatic waitIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !busy && !res_pending) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("drain_timeout", 0, 1);
      sb_q.delete();
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      n_pushed = total_done;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    dividend_in = dvd;
    divisor_in  = dvs;
    start       = 1'b1;
    sb_q.push_back(refModel(dvd, dvs));
    n_pushed++;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin : stimulus
    bit seen;
    int base;
    logic [N-1:0] dvd, dvs;
    rst_b = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outs", outs, 0);
    checkOutput("reset_busy", busy, 0);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("idle_outs", outs, 0);
    checkOutput("idle_no_load", n_load, 0);

    $display("[TB] directed divisions");
    applyStimulus(8'd100, 8'd7);   waitIdle(200);
    applyStimulus(8'd255, 8'd1);   waitIdle(200);
    applyStimulus(8'd0,   8'd255); waitIdle(200);
    applyStimulus(8'd5,   8'd200); waitIdle(200);
    applyStimulus(8'd255, 8'd255); waitIdle(200);
    applyStimulus(8'd123, 8'd0);   waitIdle(200);

    $display("[TB] random divisions");
    for (int i = 0; i < 24; i++) begin
      dvd = 8'($urandom_range(0, 255));
      dvs = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
      applyStimulus(dvd, dvs);
      waitIdle(200);
    end

    $display("[TB] start pulses while busy and in DONE");
    applyStimulus(8'd200, 8'd13);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (seen) break;
      if (done) begin
        start = 1'b1;
        seen = 1'b1;
      end else if (busy && (i % 3 == 0)) begin
        start = 1'b1;
      end
    end
    start = 1'b0;
    if (!seen) checkOutput("busy_start_timeout", 0, 1);
    waitIdle(200);
    repeat (20) @(negedge clk);

    $display("[TB] reset during the fifth pass");
    applyStimulus(8'd100, 8'd7);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (n_inc == 4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("pass4_timeout", 0, 1);
    repeat (2) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("midrun_reset_outs", outs, 0);
    checkOutput("midrun_reset_busy", busy, 0);
    sb_q.delete();
    n_pushed--;
    repeat (2) @(negedge clk);
    #1;
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    applyStimulus(8'd77, 8'd3);
    waitIdle(200);

    $display("[TB] start held high relaunches");
    base = n_load;
    dividend_in = 8'd50;
    divisor_in  = 8'd6;
    sb_q.push_back(refModel(8'd50, 8'd6));
    sb_q.push_back(refModel(8'd50, 8'd6));
    n_pushed += 2;
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (n_load == base + 2) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) checkOutput("relaunch_timeout", 0, 1);
    waitIdle(200);

    applyStimulus(8'd9, 8'd0);
    waitIdle(200);
    repeat (10) @(negedge clk);

    checkOutput("idle_bad", idle_bad, 0);
    checkOutput("done_total", total_done, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
